// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: registered N-to-log2(N) priority encoder with sticky request capture and valid/ready output.
// Optional `define ROUND_ROBIN_EN selects rotating priority instead of fixed highest-index-first.
`default_nettype none

module priority_encoder_seq #(
  parameter int N_IN  = 8,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [N_IN-1:0]  pending,
  output logic             busy
);

  generate
    if (OUT_W != $clog2(N_IN)) begin : g_bad_out_w
      $error("priority_encoder_seq: OUT_W must equal $clog2(N_IN)");
    end
    if (N_IN < 2 || N_IN > 64) begin : g_bad_n_in
      $error("priority_encoder_seq: N_IN must be in 2..64");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN-1:0]  r_pending;
  logic [OUT_W-1:0] r_dout;
  logic [OUT_W-1:0] w_dout_nxt;
  logic             r_dout_valid;
  logic             w_valid_nxt;
  logic             w_hs;
  logic [N_IN-1:0]  w_clr_mask;
  logic [OUT_W-1:0] w_sel;

  assign w_hs       = r_dout_valid & dout_ready;
  assign w_clr_mask = w_hs ? (N_IN'(1) << r_dout) : '0;

`ifdef ROUND_ROBIN_EN
  logic [OUT_W-1:0] r_rr_ptr;
  // Until the first handshake the search starts at rr_ptr itself, so the
  // first grant after reset matches the fixed-priority result.
  logic             r_rr_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= OUT_W'(N_IN - 1);
      r_rr_first <= 1'b1;
    end else if (w_hs) begin
      r_rr_ptr   <= r_dout;
      r_rr_first <= 1'b0;
    end
  end

  always_comb begin
    logic found;
    found = 1'b0;
    w_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      int               t;
      logic [OUT_W-1:0] idx;
      t = int'(r_rr_ptr) - (r_rr_first ? 0 : 1) - k;
      if (t < 0) t = t + N_IN;
      idx = OUT_W'(t);
      if (!found && r_pending[idx]) begin
        found = 1'b1;
        w_sel = idx;
      end
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_pending[i]) w_sel = OUT_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= (r_pending & ~w_clr_mask) | din;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_dout_valid;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_dout_nxt  = w_sel;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign pending    = r_pending;
  assign busy       = (|r_pending) | r_dout_valid;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_seq.sv
// tb_priority_encoder_seq: directed plus randomized checks of priority_encoder_seq against a cycle-level reference model.
`default_nettype none

module tb_priority_encoder_seq;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: captured requests, and the grant currently offered.
  logic [7:0] m_pending;
  logic       m_valid;
  logic [2:0] m_dout;

  priority_encoder_seq #(.N_IN(8), .OUT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int highest(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pending = '0;
    m_valid   = 1'b0;
    m_dout    = '0;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic r);
    logic [7:0] old_p;
    old_p = m_pending;
    if (m_valid && r) m_pending[m_dout] = 1'b0;
    m_pending = m_pending | d;
    if (m_valid) begin
      if (r) m_valid = 1'b0;
    end else if (old_p != 0) begin
      m_dout  = 3'(highest(old_p));
      m_valid = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("dout_valid", 64'(dout_valid), 64'(m_valid));
    check("dout", 64'(dout), 64'(m_dout));
    check("pending", 64'(pending), 64'(m_pending));
    check("busy", 64'(busy), 64'((m_pending != 0) || m_valid));
  endtask

  // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic step(input logic [7:0] d, input logic r);
    din        = d;
    dout_ready = r;
    @(posedge clk);
    model_edge(d, r);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    dout_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(dout_valid), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    rst = 1'b0;

    // Single request
    step(8'h04, 1'b1);
    step(8'h00, 1'b1);
    check("single_valid", 64'(dout_valid), 64'd1);
    check("single_dout", 64'(dout), 64'd2);
    step(8'h00, 1'b1);
    check("single_done_valid", 64'(dout_valid), 64'd0);
    check("single_done_pending", 64'(pending), 64'd0);

    // Multi request, fixed priority: grants 7, 4, 0
    step(8'b1001_0001, 1'b1);
    step(8'h00, 1'b1);
    check("multi_g0", 64'(dout), 64'd7);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("multi_g1", 64'(dout), 64'd4);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("multi_g2", 64'(dout), 64'd0);
    step(8'h00, 1'b1);
    check("multi_idle_busy", 64'(busy), 64'd0);

    // Backpressure with a higher request arriving mid-hold
    step(8'b0010_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step((i == 2) ? 8'b1000_0000 : 8'h00, 1'b0);
      check("bp_dout", 64'(dout), 64'd5);
      check("bp_valid", 64'(dout_valid), 64'd1);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("bp_second", 64'(dout), 64'd7);
    step(8'h00, 1'b1);

    // Set/clear collision on index 3
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    step(8'h08, 1'b1);
    check("coll_pending", 64'(pending), 64'h08);
    step(8'h00, 1'b1);
    check("coll_regrant_valid", 64'(dout_valid), 64'd1);
    check("coll_regrant_dout", 64'(dout), 64'd3);
    step(8'h00, 1'b1);

    // Async reset while holding a grant with all requests pending
    step(8'hFF, 1'b0);
    step(8'h00, 1'b0);
    check("pre_rst_valid", 64'(dout_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(dout_valid), 64'd0);
    check("async_rst_pending", 64'(pending), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(d, ($urandom_range(0, 2) != 0));
    end

    // Drain
    for (int c = 0; c < 20; c++) step(8'h00, 1'b1);
    check("drain_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
